// File: rtl/sin_approx_pkg.sv
// Shared constants and fixed-point helpers for the sin_approx pipeline.
// SIN_APPROX_REFINE_EN selects the refined (4-stage) variant of the latency constant.
package sin_approx_pkg;

  localparam int  F_DEFAULT = 16;
  localparam real TWO_PI    = 6.283185307179586;

  // Fixed-point constants derived from the fraction width f, rounded to nearest.
  function automatic longint inv_2pi_q(input int f);
    return longint'($rtoi((2.0 ** f) / TWO_PI + 0.5));
  endfunction

  function automatic longint refine_p_q(input int f);
    return longint'($rtoi(0.225 * (2.0 ** f) + 0.5));
  endfunction

  // Full-precision width of a signed w x w product.
  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

  localparam longint INV_2PI = inv_2pi_q(F_DEFAULT);
  localparam longint P       = refine_p_q(F_DEFAULT);

`ifdef SIN_APPROX_REFINE_EN
  localparam int LATENCY = 4;
`else
  localparam int LATENCY = 3;
`endif

endpackage

// File: rtl/sin_approx_if.sv
// Valid/ready stream interface carrying angles in and sine results out.
interface sin_approx_if #(
  parameter int W = 32
);
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] x;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] y;
  logic                sign;

  modport master (
    output in_valid, x, out_ready,
    input  in_ready, out_valid, y, sign
  );

  modport slave (
    input  in_valid, x, out_ready,
    output in_ready, out_valid, y, sign
  );
endinterface

// File: rtl/fxp_mul.sv
// Signed W x W fixed-point multiply: full 2W product, arithmetic shift by F, truncate to W.
module fxp_mul
  import sin_approx_pkg::*;
#(
  parameter int W = 32,
  parameter int F = 16
) (
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_i,
  output logic signed [W-1:0] p_o
);

  localparam int PW = prod_w(W);

  logic signed [PW-1:0] prod;

  assign prod = PW'(a_i) * PW'(b_i);
  assign p_o  = W'(prod >>> F);

endmodule

// File: rtl/sin_approx_pipe.sv
// Pipelined sin(x) via phase wrap to turns and a piecewise parabola, valid/ready both sides.
// Define SIN_APPROX_REFINE_EN to insert the accuracy-refinement stage (latency 4 instead of 3).
module sin_approx_pipe
  import sin_approx_pkg::*;
#(
  parameter int W = 32,
  parameter int F = 16
) (
  input logic       clk,
  input logic       rst,
  sin_approx_if.slave bus
);

  localparam logic signed [W-1:0] INV_2PI_W = W'(inv_2pi_q(F));
  localparam logic signed [W-1:0] ONE_W     = W'(longint'(1) <<< F);

  logic                adv;
  logic                out_valid_q;
  logic signed [W-1:0] y_q, y_d;
  logic                sign_q;

  logic                last_valid;
  logic signed [W-1:0] last_p;
  logic                last_sign;

  // Every stage moves together; a stalled output freezes the whole pipe.
  assign adv           = !out_valid_q || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.sign      = sign_q;

  // Stage 1: radians -> turns; the low F bits are the wrapped fraction t in [0,1).
  logic signed [W-1:0] turns;
  logic [F-1:0]        t_d, t_q;
  logic                s1_valid_q;

  fxp_mul #(.W(W), .F(F)) u_mul_turns (.a_i(bus.x), .b_i(INV_2PI_W), .p_o(turns));
  assign t_d = F'(turns);

  // Stage 2: fold the second half-turn onto the first and evaluate 8u - 16u^2.
  logic signed [W-1:0] u, u_sq, p_half, p2_d, p2_q;
  logic                sign2_q;
  logic                s2_valid_q;

  assign u = W'(t_q[F-2:0]);
  fxp_mul #(.W(W), .F(F)) u_mul_sq (.a_i(u), .b_i(u), .p_o(u_sq));
  assign p_half = (u <<< 3) - (u_sq <<< 4);
  assign p2_d   = t_q[F-1] ? -p_half : p_half;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else if (adv) begin
      s1_valid_q <= bus.in_valid;
      s2_valid_q <= s1_valid_q;
    end
  end

  // NOTE: datapath registers carry no reset; only valid flags and outputs must be cleared.
  always_ff @(posedge clk) begin
    if (adv) begin
      t_q     <= t_d;
      p2_q    <= p2_d;
      sign2_q <= t_q[F-1];
    end
  end

`ifdef SIN_APPROX_REFINE_EN
  localparam logic signed [W-1:0] P_W = W'(refine_p_q(F));

  logic signed [W-1:0] p_abs, p_sq, p_diff, p_corr, p3_d, p3_q;
  logic                sign3_q;
  logic                s3_valid_q;

  // Refinement: p' = p + P * (p*|p| - p).
  assign p_abs  = p2_q[W-1] ? -p2_q : p2_q;
  fxp_mul #(.W(W), .F(F)) u_mul_pabs (.a_i(p2_q), .b_i(p_abs), .p_o(p_sq));
  assign p_diff = p_sq - p2_q;
  fxp_mul #(.W(W), .F(F)) u_mul_corr (.a_i(P_W), .b_i(p_diff), .p_o(p_corr));
  assign p3_d   = p2_q + p_corr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_valid_q <= 1'b0;
    end else if (adv) begin
      s3_valid_q <= s2_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      p3_q    <= p3_d;
      sign3_q <= sign2_q;
    end
  end

  assign last_valid = s3_valid_q;
  assign last_p     = p3_q;
  assign last_sign  = sign3_q;
`else
  assign last_valid = s2_valid_q;
  assign last_p     = p2_q;
  assign last_sign  = sign2_q;
`endif

  // Output stage: clamp to [-1.0, +1.0].
  // NOTE: always_comb assigns a default first so no path can infer a latch.
  always_comb begin
    y_d = last_p;
    if (last_p > ONE_W) begin
      y_d = ONE_W;
    end else if (last_p < -ONE_W) begin
      y_d = -ONE_W;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
      sign_q      <= 1'b0;
    end else if (adv) begin
      out_valid_q <= last_valid;
      if (last_valid) begin
        y_q    <= y_d;
        sign_q <= last_sign;
      end
    end
  end

endmodule

// File: tb/tb_sin_approx_pipe.sv
// Self-checking bench for sin_approx_pipe: scoreboard against an arithmetic model and $sin.
module tb_sin_approx_pipe;

  localparam int     W      = 32;
  localparam int     F      = 16;
  localparam longint ONE    = 65536;
  localparam longint HALF   = ONE / 2;
  localparam longint K_INV  = 10430;   // round(65536 / 2pi)
  localparam longint K_P    = 14746;   // round(0.225 * 65536)
  localparam longint X_SPAN = 823550;  // 4pi in Q16.16
`ifdef SIN_APPROX_REFINE_EN
  localparam int  EXP_LAT = 4;
  localparam real TOL     = 131.0;
`else
  localparam int  EXP_LAT = 3;
  localparam real TOL     = 3932.0;
`endif

  typedef struct {
    longint x;
    int     acc;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  sin_approx_if #(.W(W)) bus ();
  sin_approx_pipe #(.W(W), .F(F)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int     n_checks  = 0;
  int     n_fail    = 0;
  int     n_ret     = 0;
  int     cyc       = 0;
  int     last_lat  = -1;
  bit     head_seen = 1'b0;
  bit     hold_prev = 1'b0;
  longint prev_y    = 0;
  bit     prev_sign = 1'b0;
  item_t  sbq[$];

  longint dir_x[5] = '{0, 102944, -102944, 205887, 205895};
  longint stall_x[8];

  task automatic check(input string tag, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference: wrap to turns, piecewise parabola, optional refinement, clamp.
  function automatic longint model_t(input longint xv);
    return ((xv * K_INV) >>> F) & (ONE - 1);
  endfunction

  function automatic longint model_y(input longint xv);
    longint t, uu, p;
    t  = model_t(xv);
    uu = (t >= HALF) ? t - HALF : t;
    p  = 8 * uu - 16 * ((uu * uu) >>> F);
    if (t >= HALF) p = -p;
`ifdef SIN_APPROX_REFINE_EN
    begin
      longint a;
      a = (p < 0) ? -p : p;
      p = p + ((K_P * (((p * a) >>> F) - p)) >>> F);
    end
`endif
    if (p > ONE) p = ONE;
    if (p < -ONE) p = -ONE;
    return p;
  endfunction

  task automatic retire();
    item_t  it;
    longint yv;
    real    s, err;
    n_ret++;
    if (sbq.size() == 0) begin
      check("spurious_result", 1, 0);
      return;
    end
    it        = sbq.pop_front();
    head_seen = 1'b0;
    yv        = longint'(bus.y);
    check("y_model", bus.y, model_y(it.x));
    check("sign_model", bus.sign, model_t(it.x) >= HALF);
    check("y_range", (yv <= ONE) && (yv >= -ONE), 1);
    if (it.x >= -X_SPAN && it.x <= X_SPAN) begin
      s   = $sin(real'(it.x) / 65536.0) * 65536.0;
      err = real'(yv) - s;
      if (err < 0.0) err = -err;
      check("y_vs_sin", err <= TOL, 1);
    end
  endtask

  // One cycle: drive at the falling edge, sample 1ns later, book the handshakes of the next rising edge.
  task automatic step(input bit vin, input longint xv, input bit ordy, output bit acc);
    @(negedge clk);
    bus.in_valid  = vin;
    bus.x         = W'(xv);
    bus.out_ready = ordy;
    #1;
    cyc++;
    check("in_ready_rule", bus.in_ready, !bus.out_valid || bus.out_ready);
    if (hold_prev) begin
      check("stall_y_hold", bus.y, prev_y);
      check("stall_sign_hold", bus.sign, prev_sign);
    end
    if (bus.out_valid && !head_seen && sbq.size() > 0) begin
      head_seen = 1'b1;
      last_lat  = cyc - sbq[0].acc;
    end
    hold_prev = bus.out_valid && !bus.out_ready;
    prev_y    = longint'(bus.y);
    prev_sign = bus.sign;
    if (bus.out_valid && bus.out_ready) retire();
    acc = vin && bus.in_ready;
    if (acc) sbq.push_back(item_t'{x: xv, acc: cyc});
  endtask

  task automatic drain(input string tag);
    bit a;
    int guard = 0;
    while (sbq.size() > 0 && guard < 200) begin
      step(1'b0, 0, 1'b1, a);
      guard++;
    end
    check(tag, sbq.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit     a;
    int     idx, k, guard, stall_cyc, ret0;
    longint xv;

    bus.in_valid  = 1'b0;
    bus.x         = '0;
    bus.out_ready = 1'b1;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_y", bus.y, 0);
    check("reset_sign", bus.sign, 0);
    @(negedge clk) rst = 1'b0;
    #1 check("reset_release_in_ready", bus.in_ready, 1);

    // Directed points: zero, +/-pi/2, pi, and the exact t = 0.5 boundary.
    foreach (dir_x[i]) begin
      step(1'b1, dir_x[i], 1'b1, a);
      check("dir_accept", a, 1);
      drain("dir_drain");
      check("dir_latency", last_lat, EXP_LAT);
    end

    // Eight back-to-back samples with the output stalled on cycles 4..7.
    foreach (stall_x[i]) stall_x[i] = longint'($urandom_range(2 * X_SPAN)) - X_SPAN;
    idx = 0; k = 0; stall_cyc = 0; ret0 = n_ret;
    while ((idx < 8 || sbq.size() > 0) && k < 100) begin
      step(idx < 8, stall_x[idx % 8], !(k >= 3 && k <= 6), a);
      if (a) idx++;
      if (!bus.in_ready) stall_cyc++;
      k++;
    end
    check("stall_in_ready_low_seen", stall_cyc > 0, 1);
    check("stall_all_retired", n_ret - ret0, 8);
    check("stall_queue_empty", sbq.size(), 0);

    // Reset with samples in flight: outputs clear at once and nothing stale follows.
    for (int i = 0; i < 3; i++) step(1'b1, longint'($urandom_range(2 * X_SPAN)) - X_SPAN, 1'b1, a);
    @(posedge clk);
    #2;
    check("pre_reset_out_valid", bus.out_valid, 1);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_y", bus.y, 0);
    check("midrst_sign", bus.sign, 0);
    sbq.delete();
    head_seen = 1'b0;
    hold_prev = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    rst = 1'b0;
    #1 check("midrst_release_in_ready", bus.in_ready, 1);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 0, 1'b1, a);
      check("no_stale_out_valid", bus.out_valid, 0);
    end

    // Sweep [-4pi, 4pi] in 1024 steps with random input gaps and output back-pressure.
    idx = 0; guard = 0;
    while (idx < 1024 && guard < 20000) begin
      xv = -X_SPAN + (longint'(idx) * 2 * X_SPAN) / 1023;
      step($urandom_range(9) < 8, xv, $urandom_range(9) < 7, a);
      if (a) idx++;
      guard++;
    end
    check("sweep_issued", idx, 1024);
    drain("sweep_drain");

    // Random angles in range, then a few full-width values (wrap checked against the model).
    idx = 0; guard = 0;
    while (idx < 208 && guard < 5000) begin
      if (idx < 200) xv = longint'($urandom_range(2 * X_SPAN)) - X_SPAN;
      else           xv = longint'($signed($urandom()));
      step($urandom_range(3) != 0, xv, $urandom_range(3) != 0, a);
      if (a) idx++;
      guard++;
    end
    check("random_issued", idx, 208);
    drain("random_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
